// File: rtl/bank_access_ctrl.sv
// ---------------------------------------------------------------------------
// bank_access_ctrl
//   Shares one dual-port SRAM bank (port B write, port A read) between
//   NUM_REQ requesters. Each port has its own round-robin arbiter; the
//   winning request is registered onto the SRAM pins. Read grants are tagged
//   and the tag travels down a pipe matching the SRAM read latency, so the
//   response comes back one-hot to the requester that asked for it.
//   After reset the whole bank is zero-filled (INIT_CLEAR=1) before any
//   request is granted. A read whose address matches the same-cycle write
//   winner is held off for a cycle so it returns the freshly written data.
//
// Ports
//   vsi_clk, vsi_reset   clock / synchronous active-high reset
//   wr_req_valid/ready   per-requester write handshake
//   wr_req_addr/data     packed write address / data, requester i at slice i
//   rd_req_valid/ready   per-requester read handshake
//   rd_req_addr          packed read addresses
//   rd_rsp_valid         one-hot read response strobe (no back-pressure)
//   rd_rsp_data          read response data, zero when no response
//   init_done            high once the bank clear has finished
//   sram_wr_*            SRAM port B (write) pins
//   sram_rd_en/addr      SRAM port A (read) request pins
//   sram_rd_data         SRAM port A read data
// ---------------------------------------------------------------------------
module bank_access_ctrl #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 128,
  parameter int RD_LAT     = 1,
  parameter int INIT_CLEAR = 1
) (
  input  logic                        vsi_clk,
  input  logic                        vsi_reset,
  input  logic [NUM_REQ-1:0]          wr_req_valid,
  output logic [NUM_REQ-1:0]          wr_req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]   wr_req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   wr_req_data,
  input  logic [NUM_REQ-1:0]          rd_req_valid,
  output logic [NUM_REQ-1:0]          rd_req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]   rd_req_addr,
  output logic [NUM_REQ-1:0]          rd_rsp_valid,
  output logic [DATA_W-1:0]           rd_rsp_data,
  output logic                        init_done,
  output logic                        sram_wr_en,
  output logic [ADDR_W-1:0]           sram_wr_addr,
  output logic [DATA_W-1:0]           sram_wr_data,
  output logic                        sram_rd_en,
  output logic [ADDR_W-1:0]           sram_rd_addr,
  input  logic [DATA_W-1:0]           sram_rd_data
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        clrCnt_q, clrCnt_d;
  logic [PTR_W-1:0]        wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]        rdPtr_q, rdPtr_d;
  logic                    wrEn_q, wrEn_d;
  logic [ADDR_W-1:0]       wrAddr_q, wrAddr_d;
  logic [DATA_W-1:0]       wrData_q, wrData_d;
  logic                    rdEn_q, rdEn_d;
  logic [ADDR_W-1:0]       rdAddr_q, rdAddr_d;
  logic [RD_LAT:0][NUM_REQ-1:0] tagPipe_q;

  logic                    wrFound, rdFound;
  logic [PTR_W-1:0]        wrSel, rdSel;
  logic [ADDR_W-1:0]       wrAddrSel, rdAddrSel;
  logic [DATA_W-1:0]       wrDataSel;
  logic                    rdCollide;

  // Round-robin pick: first valid requester at or after ptr, wrapping.
  // Returns {found, index}.
  function automatic logic [PTR_W:0] rrPick(input logic [NUM_REQ-1:0] valid,
                                            input logic [PTR_W-1:0]   ptr);
    logic             found;
    logic [PTR_W-1:0] sel;
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && valid[i] && (PTR_W'(i) >= ptr)) begin
        found = 1'b1;
        sel   = PTR_W'(i);
      end
    end
    // Nothing at or above ptr: wrap around to the lowest valid requester.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && valid[i]) begin
        found = 1'b1;
        sel   = PTR_W'(i);
      end
    end
    return {found, sel};
  endfunction

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] sel);
    return (sel == PTR_W'(NUM_REQ - 1)) ? '0 : sel + PTR_W'(1);
  endfunction

  // Winner selection for both ports, plus the same-address collision test.
  always_comb begin
    {wrFound, wrSel} = rrPick(wr_req_valid, wrPtr_q);
    {rdFound, rdSel} = rrPick(rd_req_valid, rdPtr_q);
    wrAddrSel = wr_req_addr[wrSel*ADDR_W +: ADDR_W];
    wrDataSel = wr_req_data[wrSel*DATA_W +: DATA_W];
    rdAddrSel = rd_req_addr[rdSel*ADDR_W +: ADDR_W];
    rdCollide = wrFound && (rdAddrSel == wrAddrSel);
  end

  // Next-state logic: INIT sweeps the clear counter over every word, then
  // RUN grants one write and one read per cycle. A colliding read yields
  // to the write and its pointer holds so the same requester retries.
  always_comb begin
    state_d      = state_q;
    clrCnt_d     = clrCnt_q;
    wrPtr_d      = wrPtr_q;
    rdPtr_d      = rdPtr_q;
    wrEn_d       = 1'b0;
    wrAddr_d     = wrAddr_q;
    wrData_d     = wrData_q;
    rdEn_d       = 1'b0;
    rdAddr_d     = rdAddr_q;
    wr_req_ready = '0;
    rd_req_ready = '0;
    case (state_q)
      ST_INIT: begin
        // The counter runs one past DEPTH-1 so RUN starts the cycle after
        // the last clear write is on the pins.
        if (clrCnt_q == CNT_W'(DEPTH)) begin
          state_d = ST_RUN;
        end else begin
          wrEn_d   = 1'b1;
          wrAddr_d = clrCnt_q[ADDR_W-1:0];
          wrData_d = '0;
          clrCnt_d = clrCnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (wrFound) begin
          wr_req_ready[wrSel] = 1'b1;
          wrEn_d              = 1'b1;
          wrAddr_d            = wrAddrSel;
          wrData_d            = wrDataSel;
          wrPtr_d             = nextPtr(wrSel);
        end
        if (rdFound && !rdCollide) begin
          rd_req_ready[rdSel] = 1'b1;
          rdEn_d              = 1'b1;
          rdAddr_d            = rdAddrSel;
          rdPtr_d             = nextPtr(rdSel);
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // State and SRAM pin registers. The tag pipe carries the one-hot grantee
  // alongside the read so responses come back in order with no lookup.
  always_ff @(posedge vsi_clk) begin
    if (vsi_reset) begin
      state_q   <= (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;
      clrCnt_q  <= '0;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      wrEn_q    <= 1'b0;
      wrAddr_q  <= '0;
      wrData_q  <= '0;
      rdEn_q    <= 1'b0;
      rdAddr_q  <= '0;
      tagPipe_q <= '0;
    end else begin
      state_q   <= state_d;
      clrCnt_q  <= clrCnt_d;
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      wrEn_q    <= wrEn_d;
      wrAddr_q  <= wrAddr_d;
      wrData_q  <= wrData_d;
      rdEn_q    <= rdEn_d;
      rdAddr_q  <= rdAddr_d;
      tagPipe_q[0] <= rd_req_ready;
      for (int i = 1; i <= RD_LAT; i++) begin
        tagPipe_q[i] <= tagPipe_q[i-1];
      end
    end
  end

  // The SRAM read port is itself registered, so its data is presented
  // directly when the matching tag leaves the pipe.
  always_comb begin
    sram_wr_en   = wrEn_q;
    sram_wr_addr = wrAddr_q;
    sram_wr_data = wrData_q;
    sram_rd_en   = rdEn_q;
    sram_rd_addr = rdAddr_q;
    init_done    = (state_q == ST_RUN);
    rd_rsp_valid = tagPipe_q[RD_LAT];
    rd_rsp_data  = (|tagPipe_q[RD_LAT]) ? sram_rd_data : '0;
  end

endmodule

// File: tb/tb_bank_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bank_access_ctrl
//   Directed bench for bank_access_ctrl with a behavioural 1-cycle SRAM.
//   Stimulus pushes expected SRAM writes, SRAM read strobes and tagged read
//   responses (with the cycle they are due) into queues; a monitor pops and
//   compares whenever the DUT presents one of those outputs.
// ---------------------------------------------------------------------------
module tb_bank_access_ctrl;

  localparam int NR    = 2;
  localparam int AW    = 7;
  localparam int DW    = 128;
  localparam int DEPTH = 128;

  localparam logic [DW-1:0] D_A5 = {16{8'hA5}};
  localparam logic [DW-1:0] D_33 = {16{8'h33}};
  localparam logic [DW-1:0] D_99 = {16{8'h99}};
  localparam logic [DW-1:0] D_FF = {16{8'hFF}};
  localparam logic [DW-1:0] D_30 = {16{8'h30}};
  localparam logic [DW-1:0] D_40 = {16{8'h40}};
  localparam logic [DW-1:0] D_41 = {16{8'h41}};

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     wr_req_valid, wr_req_ready;
  logic [NR*AW-1:0]  wr_req_addr;
  logic [NR*DW-1:0]  wr_req_data;
  logic [NR-1:0]     rd_req_valid, rd_req_ready;
  logic [NR*AW-1:0]  rd_req_addr;
  logic [NR-1:0]     rd_rsp_valid;
  logic [DW-1:0]     rd_rsp_data;
  logic              init_done;
  logic              sram_wr_en, sram_rd_en;
  logic [AW-1:0]     sram_wr_addr, sram_rd_addr;
  logic [DW-1:0]     sram_wr_data, sram_rd_data;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [NR-1:0] tag;
    int            due;
  } exp_t;

  exp_t wrQ[$];
  exp_t rdQ[$];
  exp_t rspQ[$];

  int compareCount  = 0;
  int mismatchCount = 0;
  int cycleCnt      = 0;

  logic [DW-1:0] mem [DEPTH];

  always #5 clk = ~clk;

  bank_access_ctrl #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .INIT_CLEAR(1)
  ) dut (
    .vsi_clk      (clk),
    .vsi_reset    (reset),
    .wr_req_valid (wr_req_valid),
    .wr_req_ready (wr_req_ready),
    .wr_req_addr  (wr_req_addr),
    .wr_req_data  (wr_req_data),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_req_addr  (rd_req_addr),
    .rd_rsp_valid (rd_rsp_valid),
    .rd_rsp_data  (rd_rsp_data),
    .init_done    (init_done),
    .sram_wr_en   (sram_wr_en),
    .sram_wr_addr (sram_wr_addr),
    .sram_wr_data (sram_wr_data),
    .sram_rd_en   (sram_rd_en),
    .sram_rd_addr (sram_rd_addr),
    .sram_rd_data (sram_rd_data)
  );

  // Cycle counter used to time-stamp expected events.
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Behavioural SRAM: write on port B, registered read on port A.
  always @(posedge clk) begin
    if (sram_wr_en) mem[sram_wr_addr] <= sram_wr_data;
    if (sram_rd_en) sram_rd_data <= mem[sram_rd_addr];
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cycleCnt);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT drives a write strobe,
  // read strobe or read response, and checks contents and arrival cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sram_wr_en !== 1'b0) begin
      if (wrQ.size() == 0) checkOutput("unexpected sram_wr_en", DW'(sram_wr_en), DW'(0));
      else begin
        e = wrQ.pop_front();
        checkOutput("sram_wr_addr", DW'(sram_wr_addr), DW'(e.addr));
        checkOutput("sram_wr_data", sram_wr_data, e.data);
        checkOutput("sram_wr cycle", DW'(cycleCnt), DW'(e.due));
      end
    end
    if (sram_rd_en !== 1'b0) begin
      if (rdQ.size() == 0) checkOutput("unexpected sram_rd_en", DW'(sram_rd_en), DW'(0));
      else begin
        e = rdQ.pop_front();
        checkOutput("sram_rd_addr", DW'(sram_rd_addr), DW'(e.addr));
        checkOutput("sram_rd cycle", DW'(cycleCnt), DW'(e.due));
      end
    end
    if (rd_rsp_valid !== '0) begin
      if (rspQ.size() == 0) checkOutput("unexpected rd_rsp_valid", DW'(rd_rsp_valid), DW'(0));
      else begin
        e = rspQ.pop_front();
        checkOutput("rd_rsp_valid tag", DW'(rd_rsp_valid), DW'(e.tag));
        checkOutput("rd_rsp_data", rd_rsp_data, e.data);
        checkOutput("rd_rsp cycle", DW'(cycleCnt), DW'(e.due));
      end
    end
  end

  // Drives one cycle of requests (entered #1 after a rising edge), queues
  // the hand-computed SRAM/response expectations and checks the readies.
  task automatic applyStimulus(input string name,
                               input logic [NR-1:0] wv,
                               input logic [AW-1:0] wa0, input logic [DW-1:0] wd0,
                               input logic [AW-1:0] wa1, input logic [DW-1:0] wd1,
                               input logic [NR-1:0] rv,
                               input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                               input logic [NR-1:0] expWr, input logic [NR-1:0] expRd,
                               input logic [DW-1:0] expData, input bit expectRsp);
    exp_t e;
    wr_req_valid = wv;
    wr_req_addr  = {wa1, wa0};
    wr_req_data  = {wd1, wd0};
    rd_req_valid = rv;
    rd_req_addr  = {ra1, ra0};
    if (expWr[0]) begin
      e = '{addr: wa0, data: wd0, tag: '0, due: cycleCnt + 1};
      wrQ.push_back(e);
    end
    if (expWr[1]) begin
      e = '{addr: wa1, data: wd1, tag: '0, due: cycleCnt + 1};
      wrQ.push_back(e);
    end
    if (expRd != '0) begin
      e = '{addr: (expRd[0] ? ra0 : ra1), data: '0, tag: '0, due: cycleCnt + 1};
      rdQ.push_back(e);
      if (expectRsp) begin
        e = '{addr: '0, data: expData, tag: expRd, due: cycleCnt + 2};
        rspQ.push_back(e);
      end
    end
    @(negedge clk);
    checkOutput({name, " wr_req_ready"}, DW'(wr_req_ready), DW'(expWr));
    checkOutput({name, " rd_req_ready"}, DW'(rd_req_ready), DW'(expRd));
    @(posedge clk); #1;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus("idle", 2'b00, 7'd0, '0, 7'd0, '0, 2'b00, 7'd0, 7'd0,
                             2'b00, 2'b00, '0, 1'b0);
  endtask

  // Entered #1 after the reset edge: expects 128 zero writes to addr 0..127
  // on the following cycles, no readies meanwhile, and init_done one cycle
  // after the last clear write.
  task automatic runInitCheck(input string name, input logic [NR-1:0] holdValid);
    exp_t e;
    for (int k = 0; k < DEPTH; k++) begin
      e = '{addr: AW'(k), data: '0, tag: '0, due: cycleCnt + 1 + k};
      wrQ.push_back(e);
    end
    for (int k = 0; k <= DEPTH; k++) begin
      wr_req_valid = holdValid;
      rd_req_valid = holdValid;
      wr_req_addr  = '0;
      rd_req_addr  = '0;
      wr_req_data  = '0;
      @(negedge clk);
      if (k == 0) begin
        checkOutput({name, " reset sram_wr_en"}, DW'(sram_wr_en), DW'(0));
        checkOutput({name, " reset sram_rd_en"}, DW'(sram_rd_en), DW'(0));
        checkOutput({name, " reset rd_rsp_valid"}, DW'(rd_rsp_valid), DW'(0));
      end
      checkOutput({name, " init wr_req_ready"}, DW'(wr_req_ready), DW'(0));
      checkOutput({name, " init rd_req_ready"}, DW'(rd_req_ready), DW'(0));
      checkOutput({name, " init_done low"}, DW'(init_done), DW'(0));
      @(posedge clk); #1;
    end
    wr_req_valid = '0;
    rd_req_valid = '0;
    @(negedge clk);
    checkOutput({name, " init_done high"}, DW'(init_done), DW'(1));
    @(posedge clk); #1;
  endtask

  // Main directed sequence. Pointer values in the notes are the bench's
  // own round-robin bookkeeping (write ptr w, read ptr r).
  initial begin
    reset        = 1'b1;
    wr_req_valid = '0;
    rd_req_valid = '0;
    wr_req_addr  = '0;
    rd_req_addr  = '0;
    wr_req_data  = '0;
    @(posedge clk); #1;
    reset = 1'b0;

    // T1: bank clear with requests held, which must not be granted.
    runInitCheck("T1", 2'b11);

    // T2: write addr 5 then read it back (w:0->1, r:0->1).
    applyStimulus("T2 wr", 2'b01, 7'd5, D_A5, 7'd0, '0, 2'b00, 7'd0, 7'd0, 2'b01, 2'b00, '0, 1'b0);
    applyStimulus("T2 rd", 2'b00, 7'd0, '0, 7'd0, '0, 2'b01, 7'd5, 7'd0, 2'b00, 2'b01, D_A5, 1'b1);

    // T5: parallel write addr 3 / read addr 4 by req1 (w:1->0, r:1->0).
    applyStimulus("T5", 2'b10, 7'd0, '0, 7'd3, D_33, 2'b10, 7'd0, 7'd4, 2'b10, 2'b10, '0, 1'b1);

    // T3: both requesters read for 6 cycles; grants alternate from req0.
    for (int k = 0; k < 6; k++) begin
      applyStimulus("T3", 2'b00, 7'd0, '0, 7'd0, '0, 2'b11, 7'd5, 7'd3, 2'b00,
                    (k % 2 == 0) ? 2'b01 : 2'b10, (k % 2 == 0) ? D_A5 : D_33, 1'b1);
    end

    // T4: collision on addr 9; read retries and sees new data (w:0->1, r holds 0 then ->0).
    applyStimulus("T4 collide", 2'b01, 7'd9, D_99, 7'd0, '0, 2'b10, 7'd0, 7'd9, 2'b01, 2'b00, '0, 1'b0);
    applyStimulus("T4 retry", 2'b00, 7'd0, '0, 7'd0, '0, 2'b10, 7'd0, 7'd9, 2'b00, 2'b10, D_99, 1'b1);

    // Single requester with continuous valid is granted every cycle (w:1->0).
    for (int k = 0; k < 3; k++) begin
      applyStimulus("cont wr", 2'b10, 7'd0, '0, AW'(20 + k), DW'(k + 1), 2'b00, 7'd0, 7'd0,
                    2'b10, 2'b00, '0, 1'b0);
    end

    // Address boundaries: 127 and 0 (w:0->1, r:0->0->1).
    applyStimulus("B wr127", 2'b01, 7'd127, D_FF, 7'd0, '0, 2'b00, 7'd0, 7'd0, 2'b01, 2'b00, '0, 1'b0);
    applyStimulus("B rd127", 2'b00, 7'd0, '0, 7'd0, '0, 2'b10, 7'd0, 7'd127, 2'b00, 2'b10, D_FF, 1'b1);
    applyStimulus("B rd0", 2'b00, 7'd0, '0, 7'd0, '0, 2'b01, 7'd0, 7'd0, 2'b00, 2'b01, '0, 1'b1);

    // Round-robin from r=1 with both valid: req1 first, then req0.
    applyStimulus("RR rd a", 2'b00, 7'd0, '0, 7'd0, '0, 2'b11, 7'd20, 7'd21, 2'b00, 2'b10, DW'(2), 1'b1);
    applyStimulus("RR rd b", 2'b00, 7'd0, '0, 7'd0, '0, 2'b11, 7'd20, 7'd21, 2'b00, 2'b01, DW'(1), 1'b1);

    // Only the read winner's address matters: req1 reads 31 while req1 writes 30.
    applyStimulus("P winner", 2'b10, 7'd0, '0, 7'd30, D_30, 2'b11, 7'd30, 7'd31, 2'b10, 2'b10, '0, 1'b1);

    // Collision against write winner req0; next cycle req1 writes 41 and the read of 40 goes.
    applyStimulus("C2 collide", 2'b11, 7'd40, D_40, 7'd41, D_41, 2'b01, 7'd40, 7'd0, 2'b01, 2'b00, '0, 1'b0);
    applyStimulus("C2 retry", 2'b10, 7'd0, '0, 7'd41, D_41, 2'b01, 7'd40, 7'd0, 2'b10, 2'b01, D_40, 1'b1);

    idleCycles(3);

    // T6: reset the cycle after a read grant; the response must never appear.
    applyStimulus("T6 rd", 2'b00, 7'd0, '0, 7'd0, '0, 2'b01, 7'd5, 7'd0, 2'b00, 2'b01, '0, 1'b0);
    reset = 1'b1;
    rd_req_valid = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    runInitCheck("T6", 2'b00);

    // The bank was cleared again, so addr 5 now reads back zero.
    applyStimulus("T6 post", 2'b00, 7'd0, '0, 7'd0, '0, 2'b01, 7'd5, 7'd0, 2'b00, 2'b01, '0, 1'b1);
    idleCycles(3);

    checkOutput("pending sram writes", DW'(wrQ.size()), DW'(0));
    checkOutput("pending sram reads", DW'(rdQ.size()), DW'(0));
    checkOutput("pending read responses", DW'(rspQ.size()), DW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

  // Watchdog so the run always ends on its own.
  initial begin
    #100000;
    mismatchCount++;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
